// File: rtl/wb_grf_if.sv
// Writeback-stage bus: W-stage pipeline fields in, D-stage read ports, write-back data and
// commit trace out. The master drives the W/D inputs; the slave is the register file.
interface wb_grf_if #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned NREG_LOG2 = 5
);
    logic [31:0]          W_PC;
    logic                 W_RegWrite;
    logic [2:0]           W_MemtoReg;
    logic [2:0]           W_LoadType;
    logic [NREG_LOG2-1:0] W_A3;
    logic [DATA_W-1:0]    W_ALU_C;
    logic [DATA_W-1:0]    W_HILO;
    logic [DATA_W-1:0]    W_DM_RD;
    logic [DATA_W-1:0]    W_CP0_RD;
    logic [NREG_LOG2-1:0] D_A1;
    logic [NREG_LOG2-1:0] D_A2;
    logic [DATA_W-1:0]    D_RD1;
    logic [DATA_W-1:0]    D_RD2;
    logic [DATA_W-1:0]    W_WD;
    logic                 trace_valid;
    logic [31:0]          trace_pc;
    logic [NREG_LOG2-1:0] trace_addr;
    logic [DATA_W-1:0]    trace_data;
    logic [31:0]          commit_cnt;

    modport master (
        output W_PC, W_RegWrite, W_MemtoReg, W_LoadType, W_A3,
        output W_ALU_C, W_HILO, W_DM_RD, W_CP0_RD, D_A1, D_A2,
        input  D_RD1, D_RD2, W_WD, trace_valid, trace_pc, trace_addr, trace_data, commit_cnt
    );

    modport slave (
        input  W_PC, W_RegWrite, W_MemtoReg, W_LoadType, W_A3,
        input  W_ALU_C, W_HILO, W_DM_RD, W_CP0_RD, D_A1, D_A2,
        output D_RD1, D_RD2, W_WD, trace_valid, trace_pc, trace_addr, trace_data, commit_cnt
    );
endinterface

// File: rtl/wb_grf.sv
// Writeback stage: source mux with load extension, 32-entry register file with W-to-D
// bypass, and a registered one-cycle commit trace.
module wb_grf #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned NREG_LOG2 = 5,
    parameter bit          BYPASS_EN = 1'b1
) (
    input logic    clk,
    input logic    reset,
    wb_grf_if.slave bus
);
    localparam int NREG = 2 ** NREG_LOG2;

    logic [DATA_W-1:0]    regs_q [NREG];
    logic [DATA_W-1:0]    load_data;
    logic [DATA_W-1:0]    wd;
    logic [DATA_W-1:0]    rd1;
    logic [DATA_W-1:0]    rd2;
    logic [1:0]           off;
    logic [7:0]           byte_sel;
    logic [15:0]          half_sel;
    logic                 commit;
    logic                 trace_valid_q;
    logic [31:0]          trace_pc_q;
    logic [NREG_LOG2-1:0] trace_addr_q;
    logic [DATA_W-1:0]    trace_data_q;
    logic [31:0]          commit_cnt_q;

    assign off      = bus.W_ALU_C[1:0];
    assign byte_sel = bus.W_DM_RD[8*off +: 8];
    // Halfword loads use only off[1]; misalignment is trapped upstream.
    assign half_sel = bus.W_DM_RD[16*off[1] +: 16];

    always_comb begin
        load_data = bus.W_DM_RD;
        case (bus.W_LoadType)
            3'd1:    load_data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
            3'd2:    load_data = {{(DATA_W-8){1'b0}}, byte_sel};
            3'd3:    load_data = {{(DATA_W-16){half_sel[15]}}, half_sel};
            3'd4:    load_data = {{(DATA_W-16){1'b0}}, half_sel};
            default: load_data = bus.W_DM_RD;
        endcase
    end

    always_comb begin
        wd = bus.W_ALU_C;
        case (bus.W_MemtoReg)
            3'd1:    wd = load_data;
            3'd2:    wd = bus.W_PC + 32'd8;
            3'd3:    wd = bus.W_HILO;
            3'd4:    wd = bus.W_CP0_RD;
            default: wd = bus.W_ALU_C;
        endcase
    end

    assign commit = bus.W_RegWrite && (bus.W_A3 != '0);

    always_comb begin
        rd1 = '0;
        if (bus.D_A1 != '0) begin
            if (BYPASS_EN && bus.W_RegWrite && (bus.W_A3 == bus.D_A1)) rd1 = wd;
            else rd1 = regs_q[bus.D_A1];
        end
    end

    always_comb begin
        rd2 = '0;
        if (bus.D_A2 != '0) begin
            if (BYPASS_EN && bus.W_RegWrite && (bus.W_A3 == bus.D_A2)) rd2 = wd;
            else rd2 = regs_q[bus.D_A2];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else if (commit) begin
            regs_q[bus.W_A3] <= wd;
        end
    end

    // Trace fields other than valid hold their last commit between writes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trace_valid_q <= 1'b0;
            trace_pc_q    <= '0;
            trace_addr_q  <= '0;
            trace_data_q  <= '0;
            commit_cnt_q  <= '0;
        end else begin
            trace_valid_q <= commit;
            if (commit) begin
                trace_pc_q   <= bus.W_PC;
                trace_addr_q <= bus.W_A3;
                trace_data_q <= wd;
                commit_cnt_q <= commit_cnt_q + 32'd1;
            end
        end
    end

    assign bus.W_WD        = wd;
    assign bus.D_RD1       = rd1;
    assign bus.D_RD2       = rd2;
    assign bus.trace_valid = trace_valid_q;
    assign bus.trace_pc    = trace_pc_q;
    assign bus.trace_addr  = trace_addr_q;
    assign bus.trace_data  = trace_data_q;
    assign bus.commit_cnt  = commit_cnt_q;
endmodule

// File: tb/tb_wb_grf.sv
// Bench for wb_grf: vector table for the source mux / load extension, directed corner
// sequences, and randomized traffic against an array-based register file model.
module tb_wb_grf;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    wb_grf_if #(.DATA_W(32), .NREG_LOG2(5)) bus ();
    wb_grf_if #(.DATA_W(32), .NREG_LOG2(5)) bus_nb ();

    wb_grf #(.DATA_W(32), .NREG_LOG2(5), .BYPASS_EN(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    wb_grf #(.DATA_W(32), .NREG_LOG2(5), .BYPASS_EN(1'b0)) dut_nb (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_nb)
    );

    // The no-bypass instance sees exactly the same inputs.
    assign bus_nb.W_PC       = bus.W_PC;
    assign bus_nb.W_RegWrite = bus.W_RegWrite;
    assign bus_nb.W_MemtoReg = bus.W_MemtoReg;
    assign bus_nb.W_LoadType = bus.W_LoadType;
    assign bus_nb.W_A3       = bus.W_A3;
    assign bus_nb.W_ALU_C    = bus.W_ALU_C;
    assign bus_nb.W_HILO     = bus.W_HILO;
    assign bus_nb.W_DM_RD    = bus.W_DM_RD;
    assign bus_nb.W_CP0_RD   = bus.W_CP0_RD;
    assign bus_nb.D_A1       = bus.D_A1;
    assign bus_nb.D_A2       = bus.D_A2;

    // Reference model state
    logic [31:0] m_regs [32];
    logic        m_tv;
    logic [31:0] m_tpc;
    logic [4:0]  m_taddr;
    logic [31:0] m_tdata;
    logic [31:0] m_cnt;

    typedef struct {
        logic [2:0]  memtoreg;
        logic [2:0]  loadtype;
        logic [31:0] alu_c;
        logic [31:0] dm_rd;
        logic [31:0] pc;
        logic [31:0] exp_wd;
    } vec_t;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_wd();
        logic [31:0] off, b, h, ld;
        off = bus.W_ALU_C & 32'd3;
        b   = (bus.W_DM_RD >> (8 * off)) & 32'hFF;
        h   = (bus.W_DM_RD >> (16 * (off / 2))) & 32'hFFFF;
        case (bus.W_LoadType)
            3'd1:    ld = (b >= 32'd128) ? (b | 32'hFFFFFF00) : b;
            3'd2:    ld = b;
            3'd3:    ld = (h >= 32'd32768) ? (h | 32'hFFFF0000) : h;
            3'd4:    ld = h;
            default: ld = bus.W_DM_RD;
        endcase
        case (bus.W_MemtoReg)
            3'd1:    return ld;
            3'd2:    return bus.W_PC + 32'd8;
            3'd3:    return bus.W_HILO;
            3'd4:    return bus.W_CP0_RD;
            default: return bus.W_ALU_C;
        endcase
    endfunction

    function automatic logic [31:0] model_rd(input logic [4:0] a, input bit bypass);
        if (a == 5'd0) return 32'd0;
        if (bypass && bus.W_RegWrite && bus.W_A3 == a) return model_wd();
        return m_regs[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_tv = 1'b0; m_tpc = 32'd0; m_taddr = 5'd0; m_tdata = 32'd0; m_cnt = 32'd0;
    endtask

    task automatic set_idle();
        bus.W_PC = 32'd0; bus.W_RegWrite = 1'b0; bus.W_MemtoReg = 3'd0; bus.W_LoadType = 3'd0;
        bus.W_A3 = 5'd0; bus.W_ALU_C = 32'd0; bus.W_HILO = 32'd0; bus.W_DM_RD = 32'd0;
        bus.W_CP0_RD = 32'd0; bus.D_A1 = 5'd0; bus.D_A2 = 5'd0;
    endtask

    // One clock edge; the model commits from the inputs present at the edge.
    task automatic tick();
        logic [31:0] wd;
        logic        c;
        wd = model_wd();
        c  = bus.W_RegWrite && (bus.W_A3 != 5'd0);
        @(posedge clk);
        #1;
        m_tv = c;
        if (c) begin
            m_regs[bus.W_A3] = wd;
            m_tpc = bus.W_PC; m_taddr = bus.W_A3; m_tdata = wd;
            m_cnt = m_cnt + 32'd1;
        end
    endtask

    task automatic check_all(input string tag);
        check32({tag, ".W_WD"},      bus.W_WD,          model_wd());
        check32({tag, ".RD1"},       bus.D_RD1,         model_rd(bus.D_A1, 1'b1));
        check32({tag, ".RD2"},       bus.D_RD2,         model_rd(bus.D_A2, 1'b1));
        check32({tag, ".nb_RD1"},    bus_nb.D_RD1,      model_rd(bus.D_A1, 1'b0));
        check32({tag, ".nb_RD2"},    bus_nb.D_RD2,      model_rd(bus.D_A2, 1'b0));
        check32({tag, ".tvalid"},    32'(bus.trace_valid), 32'(m_tv));
        check32({tag, ".tpc"},       bus.trace_pc,      m_tpc);
        check32({tag, ".taddr"},     32'(bus.trace_addr), 32'(m_taddr));
        check32({tag, ".tdata"},     bus.trace_data,    m_tdata);
        check32({tag, ".cnt"},       bus.commit_cnt,    m_cnt);
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] v);
        bus.W_RegWrite = 1'b1; bus.W_A3 = a; bus.W_MemtoReg = 3'd0; bus.W_ALU_C = v;
        tick();
        bus.W_RegWrite = 1'b0; bus.W_A3 = 5'd0;
    endtask

    initial begin
        vec_t vecs [12];
        logic [31:0] cnt_before;

        vecs[0]  = '{3'd1, 3'd1, 32'h3, 32'h80F17F02, 32'h0, 32'hFFFFFF80};
        vecs[1]  = '{3'd1, 3'd2, 32'h3, 32'h80F17F02, 32'h0, 32'h00000080};
        vecs[2]  = '{3'd1, 3'd3, 32'h2, 32'h80F17F02, 32'h0, 32'hFFFF80F1};
        vecs[3]  = '{3'd1, 3'd4, 32'h0, 32'h80F17F02, 32'h0, 32'h00007F02};
        vecs[4]  = '{3'd1, 3'd1, 32'h1, 32'h80F17F02, 32'h0, 32'h0000007F};
        vecs[5]  = '{3'd1, 3'd3, 32'h3, 32'h80F17F02, 32'h0, 32'hFFFF80F1};
        vecs[6]  = '{3'd1, 3'd2, 32'h2, 32'h80F17F02, 32'h0, 32'h000000F1};
        vecs[7]  = '{3'd1, 3'd6, 32'h1, 32'h80F17F02, 32'h0, 32'h80F17F02};
        vecs[8]  = '{3'd2, 3'd0, 32'h0, 32'h0,        32'hFFFFFFFC, 32'h00000004};
        vecs[9]  = '{3'd0, 3'd0, 32'hCAFE0001, 32'h0, 32'h0, 32'hCAFE0001};
        vecs[10] = '{3'd7, 3'd0, 32'h12345678, 32'h0, 32'h0, 32'h12345678};
        vecs[11] = '{3'd1, 3'd4, 32'h2, 32'h80F17F02, 32'h0, 32'h000080F1};

        set_idle();
        model_reset();
        bus.D_A1 = 5'd5;
        #3;
        check_all("reset_init");
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        #1;

        // Table: mux / load extension, W_WD is combinational
        foreach (vecs[i]) begin
            bus.W_MemtoReg = vecs[i].memtoreg; bus.W_LoadType = vecs[i].loadtype;
            bus.W_ALU_C = vecs[i].alu_c; bus.W_DM_RD = vecs[i].dm_rd; bus.W_PC = vecs[i].pc;
            #1;
            check32($sformatf("vec%0d.W_WD", i), bus.W_WD, vecs[i].exp_wd);
        end
        set_idle();
        bus.W_HILO = 32'hA5A5_0003; bus.W_CP0_RD = 32'h0C0C_0004;
        bus.W_MemtoReg = 3'd3; #1; check32("hilo.W_WD", bus.W_WD, 32'hA5A50003);
        bus.W_MemtoReg = 3'd4; #1; check32("cp0.W_WD", bus.W_WD, 32'h0C0C0004);
        set_idle();

        // PC+8 source committed to $8
        bus.W_RegWrite = 1'b1; bus.W_A3 = 5'd8; bus.W_MemtoReg = 3'd2; bus.W_PC = 32'h3000;
        #1 check32("pc8.W_WD", bus.W_WD, 32'h00003008);
        tick();
        set_idle();
        bus.D_A1 = 5'd8;
        #1;
        check32("pc8.reg8", bus.D_RD1, 32'h00003008);
        check32("pc8.tvalid", 32'(bus.trace_valid), 32'd1);
        check32("pc8.tpc", bus.trace_pc, 32'h00003000);
        check32("pc8.taddr", 32'(bus.trace_addr), 32'd8);
        check_all("pc8");

        // Same-cycle bypass on both ports; the no-bypass copy returns the stored value
        write_reg(5'd9, 32'h11111111);
        bus.W_RegWrite = 1'b1; bus.W_A3 = 5'd9; bus.W_ALU_C = 32'hDEADBEEF;
        bus.D_A1 = 5'd9; bus.D_A2 = 5'd9;
        #1;
        check32("byp.RD1", bus.D_RD1, 32'hDEADBEEF);
        check32("byp.RD2", bus.D_RD2, 32'hDEADBEEF);
        check32("nobyp.RD1", bus_nb.D_RD1, 32'h11111111);
        check32("nobyp.RD2", bus_nb.D_RD2, 32'h11111111);
        tick();
        set_idle();
        bus.D_A1 = 5'd9;
        #1 check32("byp.after", bus_nb.D_RD1, 32'hDEADBEEF);

        // $0 writes are discarded and do not commit
        cnt_before = m_cnt;
        bus.W_RegWrite = 1'b1; bus.W_A3 = 5'd0; bus.W_ALU_C = 32'hFFFFFFFF; bus.D_A1 = 5'd0;
        #1 check32("r0.before", bus.D_RD1, 32'd0);
        tick();
        check32("r0.after", bus.D_RD1, 32'd0);
        check32("r0.tvalid", 32'(bus.trace_valid), 32'd0);
        check32("r0.cnt", bus.commit_cnt, cnt_before);
        set_idle();

        // Back-to-back commits from a fresh reset
        #2 reset = 1'b0;
        model_reset();
        #3 reset = 1'b1;
        #1;
        bus.W_RegWrite = 1'b1; bus.W_MemtoReg = 3'd0;
        bus.W_A3 = 5'd3; bus.W_ALU_C = 32'hAAAA0001; tick();
        check32("b2b.tv1", 32'(bus.trace_valid), 32'd1);
        bus.W_A3 = 5'd3; bus.W_ALU_C = 32'hAAAA0002; tick();
        check32("b2b.tv2", 32'(bus.trace_valid), 32'd1);
        bus.W_A3 = 5'd4; bus.W_ALU_C = 32'hAAAA0003; tick();
        check32("b2b.tv3", 32'(bus.trace_valid), 32'd1);
        set_idle();
        bus.D_A1 = 5'd3; bus.D_A2 = 5'd4;
        tick();
        check32("b2b.tv_drop", 32'(bus.trace_valid), 32'd0);
        check32("b2b.cnt", bus.commit_cnt, 32'd3);
        check32("b2b.reg3", bus.D_RD1, 32'hAAAA0002);
        check32("b2b.reg4", bus.D_RD2, 32'hAAAA0003);
        check_all("b2b");

        // Randomized traffic against the model
        for (int n = 0; n < 300; n++) begin
            bus.W_PC       = $urandom;
            bus.W_RegWrite = ($urandom_range(0, 3) != 0);
            bus.W_MemtoReg = 3'($urandom_range(0, 7));
            bus.W_LoadType = 3'($urandom_range(0, 7));
            bus.W_A3       = 5'($urandom_range(0, 31));
            bus.W_ALU_C    = $urandom;
            bus.W_HILO     = $urandom;
            bus.W_DM_RD    = $urandom;
            bus.W_CP0_RD   = $urandom;
            bus.D_A1       = ($urandom_range(0, 2) == 0) ? bus.W_A3 : 5'($urandom_range(0, 31));
            bus.D_A2       = ($urandom_range(0, 2) == 0) ? bus.W_A3 : 5'($urandom_range(0, 31));
            #1;
            check_all($sformatf("rnd%0d", n));
            tick();
        end
        set_idle();

        // Asynchronous reset mid-run clears storage and trace without a clock edge
        write_reg(5'd5, 32'h1234);
        bus.D_A1 = 5'd5;
        #1 check32("arst.pre", bus.D_RD1, 32'h1234);
        #1 reset = 1'b0;
        model_reset();
        #1;
        check32("arst.RD1", bus.D_RD1, 32'd0);
        check32("arst.tvalid", 32'(bus.trace_valid), 32'd0);
        check32("arst.cnt", bus.commit_cnt, 32'd0);
        check_all("arst");
        @(posedge clk);
        #2 reset = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
